add3_seq: RTL and testbench

Handshaking initiator that computes a1+a2+a3 (IEEE-754 single precision) by driving one stb/ack floating-point adder twice in sequence. It acts as the master end of the adder's input_a/input_b/output_z handshake, which the adder core implements as a responder, so no operand is ever presented without a matching ack. It takes one operand triple per upstream handshake and returns the sum on a downstream handshake.

---
 rtl/add3_seq.sv | 191 +++++++++++++++++++
 tb/tb_add3_seq.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add3_seq.sv
// add3_seq: drives a stb/ack floating-point adder twice to form a1+a2+a3.
// Define SUM3_TIMEOUT_EN to enable the adder-response watchdog and sticky err.
module add3_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_a1,
    input  logic [31:0] i_a2,
    input  logic [31:0] i_a3,
    input  logic        i_in_stb,
    output logic        o_in_ack,
    output logic [31:0] o_add_a,
    output logic [31:0] o_add_b,
    output logic        o_add_a_stb,
    output logic        o_add_b_stb,
    input  logic        i_add_a_ack,
    input  logic        i_add_b_ack,
    input  logic [31:0] i_add_z,
    input  logic        i_add_z_stb,
    output logic        o_add_z_ack,
    output logic [31:0] o_result,
    output logic        o_out_stb,
    input  logic        i_out_ack,
    output logic        o_err
);

`ifdef SUM3_TIMEOUT_EN
    typedef enum logic [2:0] {
        StIdle, StSend1, StWait1, StSend2, StWait2, StDone, StErr
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StSend1, StWait1, StSend2, StWait2, StDone
    } state_e;
`endif

    state_e      r_state, w_state;
    logic        r_in_ack, w_in_ack;
    logic        r_a_stb, w_a_stb;
    logic        r_b_stb, w_b_stb;
    logic        r_z_ack, w_z_ack;
    logic        r_out_stb, w_out_stb;
    logic [31:0] r_result, w_result;
    logic [31:0] r_add_a, w_add_a;
    logic [31:0] r_add_b, w_add_b;
    logic [31:0] r_a3, w_a3;
    logic        w_a_done, w_b_done, w_busy;

    // An operand counts as taken once its strobe has dropped or its ack is present now.
    assign w_a_done = !r_a_stb || i_add_a_ack;
    assign w_b_done = !r_b_stb || i_add_b_ack;
    assign w_busy   = (r_state == StSend1) || (r_state == StWait1) ||
                      (r_state == StSend2) || (r_state == StWait2);

`ifdef SUM3_TIMEOUT_EN
    logic [15:0] r_cnt, w_cnt;
    logic        r_err, w_err;
`endif

    always_comb begin
        w_state   = r_state;
        w_in_ack  = r_in_ack;
        w_a_stb   = r_a_stb;
        w_b_stb   = r_b_stb;
        w_z_ack   = 1'b0;
        w_out_stb = r_out_stb;
        w_result  = r_result;
        w_add_a   = r_add_a;
        w_add_b   = r_add_b;
        w_a3      = r_a3;
        case (r_state)
            StIdle: begin
                w_in_ack = 1'b1;
                if (i_in_stb && r_in_ack) begin
                    w_in_ack = 1'b0;
                    w_add_a  = i_a1;
                    w_add_b  = i_a2;
                    w_a3     = i_a3;
                    w_a_stb  = 1'b1;
                    w_b_stb  = 1'b1;
                    w_state  = StSend1;
                end
            end
            StSend1, StSend2: begin
                if (i_add_a_ack) w_a_stb = 1'b0;
                if (i_add_b_ack) w_b_stb = 1'b0;
                if (w_a_done && w_b_done) begin
                    w_state = (r_state == StSend1) ? StWait1 : StWait2;
                end
            end
            StWait1: begin
                if (i_add_z_stb) begin
                    w_z_ack = 1'b1;
                    w_add_a = i_add_z;
                    w_add_b = r_a3;
                    w_a_stb = 1'b1;
                    w_b_stb = 1'b1;
                    w_state = StSend2;
                end
            end
            StWait2: begin
                if (i_add_z_stb) begin
                    w_z_ack   = 1'b1;
                    w_result  = i_add_z;
                    w_out_stb = 1'b1;
                    w_state   = StDone;
                end
            end
            StDone: begin
                if (i_out_ack) begin
                    w_out_stb = 1'b0;
                    w_in_ack  = 1'b1;
                    w_state   = StIdle;
                end
            end
            default: ;
        endcase
`ifdef SUM3_TIMEOUT_EN
        w_cnt = 16'd0;
        w_err = r_err;
        // A real state transition wins over an expiry in the same cycle.
        if (w_busy && (w_state == r_state)) begin
            if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                w_state  = StErr;
                w_err    = 1'b1;
                w_a_stb  = 1'b0;
                w_b_stb  = 1'b0;
                w_z_ack  = 1'b0;
                w_in_ack = 1'b0;
            end else begin
                w_cnt = r_cnt + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_in_ack  <= 1'b0;
            r_a_stb   <= 1'b0;
            r_b_stb   <= 1'b0;
            r_z_ack   <= 1'b0;
            r_out_stb <= 1'b0;
            r_result  <= 32'd0;
            r_add_a   <= 32'd0;
            r_add_b   <= 32'd0;
            r_a3      <= 32'd0;
        end else begin
            r_state   <= w_state;
            r_in_ack  <= w_in_ack;
            r_a_stb   <= w_a_stb;
            r_b_stb   <= w_b_stb;
            r_z_ack   <= w_z_ack;
            r_out_stb <= w_out_stb;
            r_result  <= w_result;
            r_add_a   <= w_add_a;
            r_add_b   <= w_add_b;
            r_a3      <= w_a3;
        end
    end

`ifdef SUM3_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= 16'd0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt;
            r_err <= w_err;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0) || w_busy;
    assign o_err = 1'b0;
`endif

    assign o_in_ack    = r_in_ack;
    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_add_a_stb = r_a_stb;
    assign o_add_b_stb = r_b_stb;
    assign o_add_z_ack = r_z_ack;
    assign o_result    = r_result;
    assign o_out_stb   = r_out_stb;

endmodule

// File: tb/tb_add3_seq.sv
// Self-checking bench for add3_seq: mock stb/ack adder plus a result scoreboard.
// Watchdog checks are compiled in when SUM3_TIMEOUT_EN is defined.
module tb_add3_seq;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        i_reset, i_in_stb, i_out_ack;
    logic [31:0] i_a1, i_a2, i_a3;
    logic        i_add_a_ack, i_add_b_ack, i_add_z_stb;
    logic [31:0] i_add_z;
    logic        o_in_ack, o_add_a_stb, o_add_b_stb, o_add_z_ack, o_out_stb, o_err;
    logic [31:0] o_add_a, o_add_b, o_result;

    always #5 clk = ~clk;

    add3_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_a1(i_a1), .i_a2(i_a2), .i_a3(i_a3),
        .i_in_stb(i_in_stb), .o_in_ack(o_in_ack),
        .o_add_a(o_add_a), .o_add_b(o_add_b),
        .o_add_a_stb(o_add_a_stb), .o_add_b_stb(o_add_b_stb),
        .i_add_a_ack(i_add_a_ack), .i_add_b_ack(i_add_b_ack),
        .i_add_z(i_add_z), .i_add_z_stb(i_add_z_stb), .o_add_z_ack(o_add_z_ack),
        .o_result(o_result), .o_out_stb(o_out_stb), .i_out_ack(i_out_ack),
        .o_err(o_err)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] log_a[$];
    logic [31:0] log_b[$];
    int          a_lat = 0, b_lat = 0, z_lat = 0;
    bit          z_never = 1'b0;
    bit          mock_en = 1'b1;
    logic        m_a_ack = 1'b0, m_b_ack = 1'b0, m_z_stb = 1'b0;
    logic [31:0] m_z = 32'd0;

    // Exact only for normal operands whose sums are representable (small integers here).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:0] == 31'd0) begin
            d = {f[31], 63'd0};
        end else begin
            e = {3'b000, f[30:23]} + 11'd896;
            d = {f[31], e, f[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return r2f(f2r(x) + f2r(y));
    endfunction

    // Mock adder: sole driver of the adder-side inputs; mirrors manual values when disabled.
    initial begin : mock
        int a_cnt, b_cnt, z_cnt;
        bit a_tk, b_tk, z_pend;
        logic [31:0] op_a, op_b, z_val;
        a_cnt = 0; b_cnt = 0; z_cnt = 0; a_tk = 0; b_tk = 0; z_pend = 0;
        op_a = 0; op_b = 0; z_val = 0;
        i_add_a_ack = 0; i_add_b_ack = 0; i_add_z_stb = 0; i_add_z = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!mock_en) begin
                a_cnt = 0; b_cnt = 0; z_cnt = 0; a_tk = 0; b_tk = 0; z_pend = 0;
                i_add_a_ack = m_a_ack; i_add_b_ack = m_b_ack;
                i_add_z_stb = m_z_stb; i_add_z = m_z;
            end else if (i_reset) begin
                a_cnt = 0; b_cnt = 0; z_cnt = 0; a_tk = 0; b_tk = 0; z_pend = 0;
                i_add_a_ack = 0; i_add_b_ack = 0; i_add_z_stb = 0;
            end else begin
                i_add_a_ack = 0;
                i_add_b_ack = 0;
                if (i_add_z_stb && o_add_z_ack) i_add_z_stb = 0;
                if (o_add_a_stb && !a_tk) begin
                    if (a_cnt >= a_lat) begin
                        i_add_a_ack = 1; op_a = o_add_a; a_tk = 1;
                    end else a_cnt++;
                end
                if (o_add_b_stb && !b_tk) begin
                    if (b_cnt >= b_lat) begin
                        i_add_b_ack = 1; op_b = o_add_b; b_tk = 1;
                    end else b_cnt++;
                end
                if (a_tk && b_tk) begin
                    log_a.push_back(op_a);
                    log_b.push_back(op_b);
                    z_val = fadd(op_a, op_b);
                    z_pend = 1; z_cnt = 0;
                    a_tk = 0; b_tk = 0; a_cnt = 0; b_cnt = 0;
                end
                if (z_pend && !z_never) begin
                    if (z_cnt >= z_lat) begin
                        i_add_z = z_val; i_add_z_stb = 1; z_pend = 0;
                    end else z_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_triple(input logic [31:0] a1, input logic [31:0] a2,
                               input logic [31:0] a3);
        int cyc = 0;
        while (!o_in_ack && cyc < 200) begin tick(); cyc++; end
        n_cmp++;
        if (!o_in_ack) begin
            n_fail++;
            $display("FAIL in_ack_wait: in_ack=%b want 1", o_in_ack);
            return;
        end
        i_a1 = a1; i_a2 = a2; i_a3 = a3; i_in_stb = 1'b1;
        tick();
        i_in_stb = 1'b0;
        exp_q.push_back(fadd(fadd(a1, a2), a3));
        n_cmp++;
        if ({o_add_a_stb, o_add_b_stb, o_in_ack} !== 3'b110) begin
            n_fail++;
            $display("FAIL transfer: {a_stb,b_stb,in_ack}=%b want 110",
                     {o_add_a_stb, o_add_b_stb, o_in_ack});
        end
    endtask

    task automatic collect_result(input int hold);
        int cyc = 0;
        logic [31:0] expv, held;
        while (!o_out_stb && cyc < 500) begin tick(); cyc++; end
        n_cmp++;
        if (!o_out_stb) begin
            n_fail++;
            $display("FAIL out_stb_wait: out_stb=%b want 1", o_out_stb);
            return;
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_cmp++;
        if (o_result !== expv) begin
            n_fail++;
            $display("FAIL result: got %h want %h", o_result, expv);
        end
        held = o_result;
        repeat (hold) begin
            tick();
            n_cmp++;
            if (o_out_stb !== 1'b1 || o_result !== held || o_in_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: out_stb=%b result=%h in_ack=%b want 1 %h 0",
                         o_out_stb, o_result, o_in_ack, held);
            end
        end
        i_out_ack = 1'b1;
        tick();
        i_out_ack = 1'b0;
        n_cmp++;
        if (o_out_stb !== 1'b0 || o_in_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL release: out_stb=%b in_ack=%b want 0 1", o_out_stb, o_in_ack);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({o_in_ack, o_add_a_stb, o_add_b_stb, o_add_z_ack, o_out_stb, o_err} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: {in_ack,a_stb,b_stb,z_ack,out_stb,err}=%b want 000000",
                     {o_in_ack, o_add_a_stb, o_add_b_stb, o_add_z_ack, o_out_stb, o_err});
        end
        n_cmp++;
        if ({o_result, o_add_a, o_add_b} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h add_a=%h add_b=%h want 0",
                     o_result, o_add_a, o_add_b);
        end
        i_reset = 1'b0;
        tick();
        n_cmp++;
        if (o_in_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ack_rise: in_ack=%b want 1", o_in_ack);
        end
    endtask

    task automatic test_basic();
        int cyc = 0;
        log_a.delete(); log_b.delete();
        i_out_ack = 1'b1;
        send_triple(32'h3F800000, 32'h40000000, 32'h40400000);
        while (!o_out_stb && cyc < 200) begin tick(); cyc++; end
        n_cmp++;
        if (o_out_stb !== 1'b1 || o_result !== 32'h40C00000) begin
            n_fail++;
            $display("FAIL basic_result: out_stb=%b result=%h want 1 40c00000", o_out_stb, o_result);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_cmp++;
        if (log_a.size() != 2 || log_b.size() != 2) begin
            n_fail++;
            $display("FAIL basic_adds: adder ops seen=%0d want 2", log_a.size());
        end else if ({log_a[0], log_b[0], log_a[1], log_b[1]} !==
                     {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40400000}) begin
            n_fail++;
            $display("FAIL basic_adds: ops %h+%h, %h+%h want 3f800000+40000000, 40400000+40400000",
                     log_a[0], log_b[0], log_a[1], log_b[1]);
        end
        tick();
        i_out_ack = 1'b0;
        n_cmp++;
        if (o_out_stb !== 1'b0 || o_in_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_one_cycle: out_stb=%b in_ack=%b want 0 1", o_out_stb, o_in_ack);
        end
    endtask

    task automatic test_skewed_acks();
        mock_en = 1'b0;
        tick();
        send_triple(32'h40A00000, 32'h40C00000, 32'h40E00000);
        tick();
        m_a_ack = 1'b1;
        tick();
        m_a_ack = 1'b0;
        n_cmp++;
        if ({o_add_a_stb, o_add_b_stb} !== 2'b01 || o_add_b !== 32'h40C00000) begin
            n_fail++;
            $display("FAIL skew_a_drop: a_stb=%b b_stb=%b add_b=%h want 0 1 40c00000",
                     o_add_a_stb, o_add_b_stb, o_add_b);
        end
        tick();
        n_cmp++;
        if (o_add_b_stb !== 1'b1 || o_add_b !== 32'h40C00000 || o_add_a !== 32'h40A00000) begin
            n_fail++;
            $display("FAIL skew_b_hold: b_stb=%b add_a=%h add_b=%h want 1 40a00000 40c00000",
                     o_add_b_stb, o_add_a, o_add_b);
        end
        m_b_ack = 1'b1;
        tick();
        m_b_ack = 1'b0;
        n_cmp++;
        if ({o_add_a_stb, o_add_b_stb, o_add_z_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL skew_wait1: {a_stb,b_stb,z_ack}=%b want 000",
                     {o_add_a_stb, o_add_b_stb, o_add_z_ack});
        end
        m_z = fadd(32'h40A00000, 32'h40C00000);
        m_z_stb = 1'b1;
        tick();
        m_z_stb = 1'b0;
        n_cmp++;
        if ({o_add_z_ack, o_add_a_stb, o_add_b_stb} !== 3'b111 ||
            o_add_a !== 32'h41300000 || o_add_b !== 32'h40E00000) begin
            n_fail++;
            $display("FAIL skew_send2: z_ack=%b stbs=%b%b add_a=%h add_b=%h want 1 11 41300000 40e00000",
                     o_add_z_ack, o_add_a_stb, o_add_b_stb, o_add_a, o_add_b);
        end
        mock_en = 1'b1;
        tick();
        n_cmp++;
        if (o_add_z_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_z_ack_pulse: z_ack=%b want 0", o_add_z_ack);
        end
        collect_result(0);
    endtask

    task automatic test_backpressure();
        i_out_ack = 1'b0;
        send_triple(32'h3F800000, 32'h3F800000, 32'h3F800000);
        collect_result(10);
    endtask

    task automatic test_reset_wait2();
        int cyc = 0;
        int base;
        base = log_a.size();
        z_lat = 20;
        send_triple(32'h41000000, 32'h41100000, 32'h41200000);
        while (log_a.size() < base + 2 && cyc < 200) begin tick(); cyc++; end
        tick(); tick();
        n_cmp++;
        if (log_a.size() != base + 2 || {o_add_a_stb, o_add_b_stb, o_out_stb} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_reach_wait2: ops=%0d stbs=%b%b out_stb=%b want %0d 00 0",
                     log_a.size(), o_add_a_stb, o_add_b_stb, o_out_stb, base + 2);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        z_lat = 0;
        n_cmp++;
        if ({o_in_ack, o_add_a_stb, o_add_b_stb, o_add_z_ack, o_out_stb, o_err} !== 6'd0 ||
            {o_result, o_add_a, o_add_b} !== 96'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: ctrl=%b result=%h add_a=%h add_b=%h want 0",
                     {o_in_ack, o_add_a_stb, o_add_b_stb, o_add_z_ack, o_out_stb, o_err},
                     o_result, o_add_a, o_add_b);
        end
        tick();
        n_cmp++;
        if (o_in_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_in_ack: in_ack=%b want 1", o_in_ack);
        end
        send_triple(32'h40800000, 32'h40A00000, 32'h40C00000);
        collect_result(0);
    endtask

    task automatic test_stray();
        mock_en = 1'b0;
        m_z_stb = 1'b1; m_z = 32'hDEADBEEF; m_a_ack = 1'b1; m_b_ack = 1'b1;
        i_out_ack = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({o_in_ack, o_add_z_ack, o_out_stb, o_add_a_stb, o_add_b_stb} !== 5'b10000) begin
            n_fail++;
            $display("FAIL stray_idle: {in_ack,z_ack,out_stb,a_stb,b_stb}=%b want 10000",
                     {o_in_ack, o_add_z_ack, o_out_stb, o_add_a_stb, o_add_b_stb});
        end
        m_z_stb = 1'b0; m_a_ack = 1'b0; m_b_ack = 1'b0;
        i_out_ack = 1'b0;
        tick();
        send_triple(32'h40000000, 32'h40000000, 32'h40000000);
        i_out_ack = 1'b1;
        m_z_stb = 1'b1;
        tick(); tick();
        i_out_ack = 1'b0;
        m_z_stb = 1'b0;
        n_cmp++;
        if ({o_add_a_stb, o_add_b_stb, o_add_z_ack, o_out_stb} !== 4'b1100 ||
            o_add_a !== 32'h40000000) begin
            n_fail++;
            $display("FAIL stray_send1: {a_stb,b_stb,z_ack,out_stb}=%b add_a=%h want 1100 40000000",
                     {o_add_a_stb, o_add_b_stb, o_add_z_ack, o_out_stb}, o_add_a);
        end
        tick();
        mock_en = 1'b1;
        collect_result(0);
    endtask

    task automatic test_watchdog();
        int cyc = 0;
        z_never = 1'b1;
        send_triple(32'h3F800000, 32'h40000000, 32'h40800000);
        while ((o_add_a_stb || o_add_b_stb) && cyc < 50) begin tick(); cyc++; end
        cyc = 0;
`ifdef SUM3_TIMEOUT_EN
        while (!o_err && cyc < 100) begin tick(); cyc++; end
        n_cmp++;
        if (o_err !== 1'b1 || cyc != TO) begin
            n_fail++;
            $display("FAIL wd_fire: err=%b after %0d cycles want 1 after %0d", o_err, cyc, TO);
        end
        n_cmp++;
        if ({o_add_a_stb, o_add_b_stb, o_add_z_ack, o_in_ack, o_out_stb} !== 5'd0) begin
            n_fail++;
            $display("FAIL wd_outputs: {a_stb,b_stb,z_ack,in_ack,out_stb}=%b want 00000",
                     {o_add_a_stb, o_add_b_stb, o_add_z_ack, o_in_ack, o_out_stb});
        end
        repeat (5) tick();
        n_cmp++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_sticky: err=%b want 1", o_err);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        z_never = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        n_cmp++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_reset: err=%b want 0", o_err);
        end
`else
        begin
            bit saw_err = 1'b0;
            repeat (300) begin
                tick();
                if (o_err !== 1'b0 || o_out_stb !== 1'b0) saw_err = 1'b1;
            end
            n_cmp++;
            if (saw_err) begin
                n_fail++;
                $display("FAIL no_wd_wait: err or out_stb rose while adder silent, want 0");
            end
            z_never = 1'b0;
            collect_result(0);
        end
`endif
    endtask

    initial begin : main
        i_reset = 1'b1; i_in_stb = 1'b0; i_out_ack = 1'b0;
        i_a1 = 32'd0; i_a2 = 32'd0; i_a3 = 32'd0;
        test_reset();
        test_basic();
        test_skewed_acks();
        test_backpressure();
        test_reset_wait2();
        test_stray();
        test_watchdog();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
